blink_seq: RTL and testbench
============================

BLINK_SEQ -- requirements
Module: blink_seq

Interface
- REQ-001 SHALL have parameter TICK_DIV, default 12_500_000, clk cycles per sequencer tick (4 Hz at 50 MHz); legal range 2..2^32-1.
- REQ-002 SHALL have parameter CNT_W, default 8, width of the burst pulse count.
- REQ-003 SHALL have port clk  input  1  50 MHz system clock, the only clock.
- REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
- REQ-005 SHALL have port cmd_valid  input  1  command offered.
- REQ-006 SHALL have port cmd_ready  output  1  command can be accepted.
- REQ-007 SHALL have port cmd_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- REQ-008 SHALL have port cmd_count  input  CNT_W  pulse count, used only for BURST.
- REQ-009 SHALL have port busy  output  1  high while a burst is in progress.
- REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
- REQ-011 SHALL have port LED  output  1  registered LED drive.
- REQ-012 SHALL have port TEST_IO  output  8  debug probe bus.

Function
- REQ-013 SHALL run a 32-bit prescaler counting 0..TICK_DIV-1 and wrapping to 0, asserting tick for one cycle when the count equals TICK_DIV-1.
- REQ-014 SHALL accept a command on a rising clk edge when cmd_valid and cmd_ready are both high, and SHALL clear the prescaler to 0 on that same edge.
- REQ-015 SHALL implement states IDLE, ON, BLINK, BURST_HI and BURST_LO.
- REQ-016 SHALL hold cmd_ready=1 in IDLE, ON and BLINK, and cmd_ready=0 in BURST_HI and BURST_LO, so a burst cannot be pre-empted.
- REQ-017 SHALL update LED on the edge that accepts a command, so the new level is visible in the following cycle (latency 1): OFF -> IDLE with LED=0; ON -> ON with LED=1; BLINK -> BLINK with LED=1; BURST with N>0 -> BURST_HI with LED=1 and remaining=N.
- REQ-018 SHALL, in BLINK, invert LED on every tick.
- REQ-019 SHALL, in BURST_HI on tick, go to BURST_LO with LED=0 and decrement remaining.
- REQ-020 SHALL, in BURST_LO on tick, go to BURST_HI with LED=1 if remaining>0, else go to IDLE and pulse done for one cycle.
- REQ-021 SHALL, for BURST with cmd_count=0, go to IDLE with LED=0, pulse done in the following cycle and never assert busy.
- REQ-022 SHALL give an accepted command priority over a tick that occurs in the same cycle; that tick is discarded.
- REQ-023 SHALL assert busy exactly while in BURST_HI or BURST_LO.
- REQ-024 SHALL treat cmd_count as unsigned and SHALL sample it only at acceptance.

Reset
- REQ-025 SHALL, while rst is high and asynchronously to clk, force state=IDLE, LED=0, prescaler=0, remaining=0, done=0, busy=0, cmd_ready=1 and TEST_IO=0.
- REQ-026 SHALL abort any burst in progress when rst is asserted, without asserting done.
- REQ-027 SHALL resume normal operation on the first clk edge after rst is deasserted.

Configuration
- REQ-028 SHALL, when BLINK_SEQ_TEST_IO_EN is defined, drive TEST_IO[0]=tick, [1]=LED, [4:2]=state code (IDLE=0, ON=1, BLINK=2, BURST_HI=3, BURST_LO=4), [5]=cmd_ready, [6]=done, [7]=busy.
- REQ-029 SHALL, when BLINK_SEQ_TEST_IO_EN is not defined, tie TEST_IO to 8'h00 with no probe logic instantiated.

Structure
- REQ-030 SHALL place the mode encodings, the state type and codes, and the TICK_DIV default in the shared package blink_seq_pkg.
- REQ-031 SHALL implement the prescaler as sub-module blink_tick_gen, with inputs clk, rst and clr and output tick.

Verification (TICK_DIV=4)
- REQ-032 SHALL cover: BLINK accepted at cycle 0 -> LED=1 from cycle 1, LED toggles at cycles 4, 8 and 12.
- REQ-033 SHALL cover: BURST with N=3 -> LED high 4 cycles / low 4 cycles, three times; done high for one cycle immediately after the third low phase; busy and cmd_ready=0 for all 24 cycles.
- REQ-034 SHALL cover: BURST with N=0 -> done pulses in cycle 1, LED stays 0, busy stays 0.
- REQ-035 SHALL cover: in BLINK, an ON command accepted on a tick cycle -> LED=1 held, no toggle, prescaler restarts from 0.
- REQ-036 SHALL cover: rst asserted mid-BURST between clk edges -> LED=0 and busy=0 immediately, no done pulse, cmd_ready=1.
- REQ-037 SHALL cover: build without BLINK_SEQ_TEST_IO_EN -> TEST_IO==8'h00 throughout all scenarios above.

Source files
------------

// File: rtl/blink_seq_pkg.sv
// Shared definitions for the blink_seq LED sequencer: command mode
// encodings, FSM state type with its probe codes, and the default
// prescaler divide (4 Hz ticks from a 50 MHz clock).
package blink_seq_pkg;

    // Default clk cycles per sequencer tick: 50 MHz / 12.5M = 4 Hz
    localparam int unsigned TICK_DIV_DEF = 12_500_000;

    // Command mode encodings as presented on cmd_mode
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    // FSM states; the encodings double as the TEST_IO state code
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ON       = 3'd1,
        ST_BLINK    = 3'd2,
        ST_BURST_HI = 3'd3,
        ST_BURST_LO = 3'd4
    } state_t;

    // A burst owns the LED until it finishes; no command may pre-empt it
    function automatic logic in_burst(input state_t s);
        return (s == ST_BURST_HI) || (s == ST_BURST_LO);
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Free-running 32-bit prescaler for blink_seq. Counts 0..TICK_DIV-1 and
// wraps; tick is high for the single cycle in which the count sits at
// TICK_DIV-1. clr restarts the count from 0 on the next edge so a newly
// accepted command always gets a full tick period before its first tick.
module blink_tick_gen
    import blink_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

    logic [31:0] cnt;

    // Prescaler count: cleared on command acceptance, wraps at LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 32'd0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= 32'd0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/blink_seq.sv
// blink_seq: command-driven LED sequencer (OFF / ON / BLINK / BURST).
// A command is taken when cmd_valid && cmd_ready; the LED level changes on
// that same edge and the prescaler restarts. Bursts emit cmd_count high/low
// pulse pairs, one tick per phase, and cannot be interrupted except by rst.
// Optional debug probe: define BLINK_SEQ_TEST_IO_EN to drive TEST_IO with
// {busy, done, cmd_ready, state[2:0], LED, tick}; otherwise TEST_IO is 0.
module blink_seq
    import blink_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             busy,
    output logic             done,
    output logic             LED,
    output logic [7:0]       TEST_IO
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             tick;
    logic             accept;

    assign accept = cmd_valid && cmd_ready;

    blink_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    // Sequencer FSM; all outputs registered. An accepted command wins over
    // a coincident tick, and that tick is dropped (the prescaler restarts).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            LED       <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                case (mode_t'(cmd_mode))
                    MODE_OFF: begin
                        state <= ST_IDLE;
                        LED   <= 1'b0;
                    end
                    MODE_ON: begin
                        state <= ST_ON;
                        LED   <= 1'b1;
                    end
                    MODE_BLINK: begin
                        state <= ST_BLINK;
                        LED   <= 1'b1;
                    end
                    MODE_BURST: begin
                        if (cmd_count != '0) begin
                            state     <= ST_BURST_HI;
                            LED       <= 1'b1;
                            remaining <= cmd_count;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                        end else begin
                            // Empty burst completes at once without ever
                            // looking busy
                            state <= ST_IDLE;
                            LED   <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (tick) begin
                case (state)
                    ST_BLINK: begin
                        LED <= ~LED;
                    end
                    ST_BURST_HI: begin
                        state     <= ST_BURST_LO;
                        LED       <= 1'b0;
                        remaining <= remaining - 1'b1;
                    end
                    ST_BURST_LO: begin
                        if (remaining != '0) begin
                            state <= ST_BURST_HI;
                            LED   <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BLINK_SEQ_TEST_IO_EN
    // Probe bus; held at zero during reset even though cmd_ready is 1 then
    assign TEST_IO = rst ? 8'h00 : {busy, done, cmd_ready, state, LED, tick};
`else
    assign TEST_IO = 8'h00;
`endif

endmodule

// File: tb/tb_blink_seq.sv
// Scoreboard bench for blink_seq at TICK_DIV=4. The stimulus process sets
// inputs just after each rising edge and queues the hand-derived outputs
// expected for that cycle; a monitor pops and compares on each falling edge.
module tb_blink_seq;
    import blink_seq_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_mode = 2'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             busy;
    logic             done;
    logic             LED;
    logic [7:0]       TEST_IO;

    blink_seq #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .busy      (busy),
        .done      (done),
        .LED       (LED),
        .TEST_IO   (TEST_IO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  led;
        logic  bsy;
        logic  dn;
        logic  rdy;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk1(input string tag, input string fld, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0b expected=%0b", tag, fld, act, exp);
        end
    endtask

    task automatic chk8(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%02h expected=%02h", tag, fld, act, exp);
        end
    endtask

    // Monitor: compare the DUT against whatever the stimulus queued for this cycle
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk1(e.tag, "LED", LED, e.led);
                chk1(e.tag, "busy", busy, e.bsy);
                chk1(e.tag, "done", done, e.dn);
                chk1(e.tag, "cmd_ready", cmd_ready, e.rdy);
`ifndef BLINK_SEQ_TEST_IO_EN
                chk8(e.tag, "TEST_IO", TEST_IO, 8'h00);
`endif
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] m, input logic [CNT_W-1:0] c,
                        input logic el, input logic eb, input logic ed, input logic er,
                        input string tag);
        @(posedge clk);
        #1;
        cmd_valid = v;
        cmd_mode  = m;
        cmd_count = c;
        sbq.push_back('{el, eb, ed, er, tag});
    endtask

    task automatic run(input int n, input logic v, input logic [1:0] m, input logic [CNT_W-1:0] c,
                       input logic el, input logic eb, input logic ed, input logic er,
                       input string tag);
        for (int i = 0; i < n; i++)
            step(v, m, c, el, eb, ed, er, $sformatf("%s[%0d]", tag, i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        run(2, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "rst_hold");
        rst = 1'b0;
        step(1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "idle");

        // BLINK: LED 1 for 4 cycles, then toggles every 4
        step(1'b1, MODE_BLINK, 8'd0, 0, 0, 0, 1, "blink_offer");
        run(4, 1'b0, MODE_OFF, 8'd0, 1, 0, 0, 1, "blink_ph1");
        run(4, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "blink_ph2");
        run(4, 1'b0, MODE_OFF, 8'd0, 1, 0, 0, 1, "blink_ph3");
        run(3, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "blink_ph4");
        // ON accepted on a tick cycle: LED goes 1 and stays, no toggle
        step(1'b1, MODE_ON, 8'd0, 0, 0, 0, 1, "on_at_tick");
        run(6, 1'b0, MODE_OFF, 8'd0, 1, 0, 0, 1, "on_hold");

        // BLINK re-accepted on its own tick: tick dropped, full period restarts
        step(1'b1, MODE_BLINK, 8'd0, 1, 0, 0, 1, "blink2_offer");
        run(3, 1'b0, MODE_OFF, 8'd0, 1, 0, 0, 1, "blink2_pre");
        step(1'b1, MODE_BLINK, 8'd0, 1, 0, 0, 1, "blink_at_tick");
        run(4, 1'b0, MODE_OFF, 8'd0, 1, 0, 0, 1, "blink2_hold");
        run(3, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "blink2_lo");
        step(1'b1, MODE_OFF, 8'd0, 0, 0, 0, 1, "off_at_tick");
        run(3, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "off_idle");

        // BURST N=3; an ON command is held offered throughout and must be ignored
        step(1'b1, MODE_BURST, 8'd3, 0, 0, 0, 1, "burst3_offer");
        for (int p = 0; p < 3; p++) begin
            run(4, 1'b1, MODE_ON, 8'd0, 1, 1, 0, 0, $sformatf("burst3_hi%0d", p));
            run(4, 1'b1, MODE_ON, 8'd0, 0, 1, 0, 0, $sformatf("burst3_lo%0d", p));
        end
        step(1'b0, MODE_OFF, 8'd0, 0, 0, 1, 1, "burst3_done");
        run(2, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "burst3_after");

        // BURST N=0: immediate done, never busy
        step(1'b1, MODE_BURST, 8'd0, 0, 0, 0, 1, "burst0_offer");
        step(1'b0, MODE_OFF, 8'd0, 0, 0, 1, 1, "burst0_done");
        run(2, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "burst0_after");

        // BURST N=1: single pulse
        step(1'b1, MODE_BURST, 8'd1, 0, 0, 0, 1, "burst1_offer");
        run(4, 1'b0, MODE_OFF, 8'd0, 1, 1, 0, 0, "burst1_hi");
        run(4, 1'b0, MODE_OFF, 8'd0, 0, 1, 0, 0, "burst1_lo");
        step(1'b0, MODE_OFF, 8'd0, 0, 0, 1, 1, "burst1_done");
        step(1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "burst1_after");

        // Reset asserted between edges in the middle of a BURST
        step(1'b1, MODE_BURST, 8'd5, 0, 0, 0, 1, "burst5_offer");
        run(4, 1'b0, MODE_OFF, 8'd0, 1, 1, 0, 0, "burst5_hi");
        run(2, 1'b0, MODE_OFF, 8'd0, 0, 1, 0, 0, "burst5_lo");
        @(posedge clk);
        #2;
        rst = 1'b1;
        cmd_valid = 1'b0;
        sbq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, "rst_async"});
        run(2, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "rst_mid");
        rst = 1'b0;
        run(12, 1'b0, MODE_OFF, 8'd0, 0, 0, 0, 1, "post_rst");

        // Normal operation resumes after reset
        step(1'b1, MODE_BLINK, 8'd0, 0, 0, 0, 1, "resume_offer");
        run(2, 1'b0, MODE_OFF, 8'd0, 1, 0, 0, 1, "resume");

        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
